fft_result_reader: RTL and testbench
====================================

// Module: fft_result_reader
// PURPOSE
//  DMA-side consumer of the R2FFT output bus. When the FFT core reports done, this block
//  reads bins 0..OUT_BINS-1 over dmaact/dmaa, takes the 1-cycle-latency dmadr_real/imag,
//  tags each bin with the frame's BFP exponent, and streams bins out on a valid/ready port.
//  It then pulses fin so the core re-arms for the next input frame.
// PARAMETERS
//  FFT_LENGTH  1024             FFT frame length, 2^N; must match the core
//  FFT_DW      16               real/imag data width
//  OUT_BINS    FFT_LENGTH/2     bins read per frame (1..FFT_LENGTH); half spectrum for real input
//  FFT_N       $clog2(FFT_LENGTH)  derived, do not override
// PORTS
//  clk         in   1        clock
//  reset       in   1        synchronous, active-high
//  fft_done    in   1        core done flag (status[2]); level
//  fft_bfpexp  in   8 s      core block-floating-point exponent; valid while fft_done
//  fin         out  1        one-cycle pulse: frame fully consumed, core may restart
//  dmaact      out  1        DMA read strobe
//  dmaa        out  FFT_N    DMA bin address
//  dmadr_real  in   FFT_DW s read data, valid exactly 1 cycle after dmaact
//  dmadr_imag  in   FFT_DW s read data, valid exactly 1 cycle after dmaact
//  out_valid   out  1        output bin valid
//  out_ready   in   1        downstream accept
//  out_bin     out  FFT_N    bin index of current output
//  out_real    out  FFT_DW s bin real part (mantissa)
//  out_imag    out  FFT_DW s bin imag part (mantissa)
//  out_exp     out  8 s      frame exponent latched at frame start
//  out_last    out  1        high with final bin (index OUT_BINS-1)
//  busy        out  1        high in any state other than IDLE
//  err_abort   out  1        sticky: fft_done fell mid-frame; cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE; fin, dmaact, out_valid, out_last, busy, err_abort = 0; dmaa, out_* = 0;
//   output buffer emptied; in-flight read discarded.
//  States: IDLE -> LATCH -> READ -> DRAIN -> FIN -> WAIT_CLR -> IDLE.
//   IDLE: on fft_done=1 go to LATCH.
//   LATCH (1 cyc): capture fft_bfpexp into out_exp reg; rd_addr=0.
//   READ: issue reads (dmaact=1, dmaa=rd_addr, rd_addr++) subject to credit rule.
//     After the read of OUT_BINS-1 is issued, go to DRAIN.
//   DRAIN: wait until no read in flight and buffer empty (last bin accepted).
//   FIN (1 cyc): fin=1. WAIT_CLR: hold until fft_done=0, then IDLE (no retrigger on stale done).
//  Output buffer: 2-entry FIFO of {bin, real, imag, last}. Write one entry the cycle after each
//   dmaact. out_valid = FIFO not empty; head is presented combinationally from FIFO regs.
//   Pop on out_valid && out_ready.
//  Credit rule: issue a read in cycle t iff occ + inflight - pop(t) < 2, where occ = entries at
//   start of cycle, inflight = dmaact of t-1, pop(t) = out_valid&&out_ready.
//   With out_ready held 1 this gives 1 bin/cycle. FIFO never overflows; no bin is dropped
//   or duplicated.
//  Latency: fft_done rise -> first dmaact = 2 cycles; dmaact -> out_valid = 1 cycle.
//  out_exp is constant for the whole frame; fft_bfpexp changes after LATCH are ignored.
//  out_last is set on the entry with bin OUT_BINS-1 only. fin asserts the cycle after that entry pops.
//  Abort: if fft_done=0 in READ or DRAIN, flush FIFO, ignore in-flight data, set err_abort,
//   go to IDLE with no fin pulse.
//  OUT_BINS=1: a single read; that bin carries out_last.
//  Reset mid-frame: immediate return to reset values. The core is not re-armed (no fin).
// TESTING
//  T1 FFT_LENGTH=8, OUT_BINS=4, out_ready=1, fft_done rises at cycle 0:
//     dmaa=0,1,2,3 on cycles 2..5; out_bin 0..3 on cycles 3..6; out_last on cycle 6; fin on cycle 7.
//  T2 same config, out_ready=1,0,0,1,0,1,1,...: all 4 bins delivered in order, each exactly once,
//     data matching model RAM; never more than 2 reads outstanding plus buffered.
//  T3 fft_bfpexp=-3 at LATCH, changed to 5 mid-frame: every out_exp=-3.
//  T4 fft_done dropped after 2 bins issued: err_abort=1, out_valid=0 next cycle,
//     fin never pulses, state returns to IDLE.
//  T5 reset asserted during READ with 1 entry buffered: all outputs 0 the next cycle;
//     a new fft_done starts from dmaa=0.
//  T6 two back-to-back frames (core drops done after fin, re-raises later):
//     second frame re-reads from bin 0; fin pulses once per frame; no retrigger while done is stale.

Source files
------------

// File: rtl/fft_result_reader.sv
// fft_result_reader: DMA-side consumer of the R2FFT output bus.
// When the core reports done, bins 0..OUT_BINS-1 are read over dmaact/dmaa.
// Each bin is tagged with the frame's block-floating-point exponent and
// streamed out on a valid/ready port. A fin pulse then re-arms the core.
module fft_result_reader #(
  parameter int  FFT_LENGTH = 1024,
  parameter int  FFT_DW     = 16,
  parameter int  OUT_BINS   = FFT_LENGTH / 2,
  localparam int FFT_N      = $clog2(FFT_LENGTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fft_done,
  input  logic signed [7:0]        fft_bfpexp,
  output logic                     fin,
  output logic                     dmaact,
  output logic        [FFT_N-1:0]  dmaa,
  input  logic signed [FFT_DW-1:0] dmadr_real,
  input  logic signed [FFT_DW-1:0] dmadr_imag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [FFT_N-1:0]  out_bin,
  output logic signed [FFT_DW-1:0] out_real,
  output logic signed [FFT_DW-1:0] out_imag,
  output logic signed [7:0]        out_exp,
  output logic                     out_last,
  output logic                     busy,
  output logic                     err_abort
);

  localparam logic [FFT_N-1:0] LAST_BIN = FFT_N'(OUT_BINS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_READ,
    S_DRAIN,
    S_FIN,
    S_WAIT_CLR
  } state_e;

  state_e state_q, state_d;

  logic        [FFT_N-1:0]  rdAddr_q;
  logic signed [7:0]        exp_q;
  logic                     errAbort_q;
  logic                     inflight_q;
  logic        [FFT_N-1:0]  inflightBin_q;
  logic                     inflightLast_q;

  logic        [1:0]        occ_q;
  logic                     rdPtr_q;
  logic                     wrPtr_q;
  logic        [FFT_N-1:0]  binMem_q  [2];
  logic signed [FFT_DW-1:0] realMem_q [2];
  logic signed [FFT_DW-1:0] imagMem_q [2];
  logic                     lastMem_q [2];

  logic                     fifoHasData;
  logic                     validInt;
  logic                     pop;
  logic                     popFifo;
  logic                     pushFifo;
  logic        [2:0]        committed;
  logic                     creditOk;
  logic                     abort;

  // Handshake bookkeeping. A read returning while the FIFO is empty is shown
  // straight from the DMA bus, so a bin is visible the cycle after its read;
  // it only enters the FIFO if it is not accepted in that same cycle.
  always_comb begin
    fifoHasData = (occ_q != 2'd0);
    validInt    = fifoHasData || inflight_q;
    pop         = validInt && out_ready;
    popFifo     = pop && fifoHasData;
    pushFifo    = inflight_q && !(pop && !fifoHasData);
    committed   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    creditOk    = (committed < 3'd2);
    abort       = !fft_done && ((state_q == S_READ) || (state_q == S_DRAIN));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a lost done flag mid-frame returns straight to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (fft_done) state_d = S_LATCH;
      S_LATCH:    state_d = S_READ;
      S_READ: begin
        if (!fft_done) begin
          state_d = S_IDLE;
        end else if (dmaact && (rdAddr_q == LAST_BIN)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!fft_done) begin
          state_d = S_IDLE;
        end else if (committed == 3'd0) begin
          state_d = S_FIN;
        end
      end
      S_FIN:      state_d = S_WAIT_CLR;
      S_WAIT_CLR: if (!fft_done) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // FSM outputs: reads are issued only while buffer plus in-flight stays under two.
  always_comb begin
    fin    = (state_q == S_FIN);
    busy   = (state_q != S_IDLE);
    dmaact = (state_q == S_READ) && fft_done && creditOk;
    dmaa   = dmaact ? rdAddr_q : '0;
  end

  // Read address, frame exponent, in-flight tag, FIFO pointers and abort flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdAddr_q       <= '0;
      exp_q          <= '0;
      errAbort_q     <= 1'b0;
      inflight_q     <= 1'b0;
      inflightBin_q  <= '0;
      inflightLast_q <= 1'b0;
      occ_q          <= 2'd0;
      rdPtr_q        <= 1'b0;
      wrPtr_q        <= 1'b0;
    end else if (abort) begin
      errAbort_q <= 1'b1;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      rdPtr_q    <= 1'b0;
      wrPtr_q    <= 1'b0;
    end else begin
      if (state_q == S_LATCH) begin
        rdAddr_q <= '0;
        exp_q    <= fft_bfpexp;
      end else if (dmaact) begin
        rdAddr_q <= rdAddr_q + FFT_N'(1);
      end
      inflight_q     <= dmaact;
      inflightBin_q  <= rdAddr_q;
      inflightLast_q <= (rdAddr_q == LAST_BIN);
      if (pushFifo) wrPtr_q <= ~wrPtr_q;
      if (popFifo)  rdPtr_q <= ~rdPtr_q;
      occ_q <= occ_q + {1'b0, pushFifo} - {1'b0, popFifo};
    end
  end

  // FIFO storage; contents are meaningless once occupancy is cleared.
  always_ff @(posedge clk) begin
    if (pushFifo) begin
      binMem_q[wrPtr_q]  <= inflightBin_q;
      realMem_q[wrPtr_q] <= dmadr_real;
      imagMem_q[wrPtr_q] <= dmadr_imag;
      lastMem_q[wrPtr_q] <= inflightLast_q;
    end
  end

  // Output head: FIFO head first, otherwise the returning read, otherwise zero.
  always_comb begin
    out_bin  = '0;
    out_real = '0;
    out_imag = '0;
    out_last = 1'b0;
    if (fifoHasData) begin
      out_bin  = binMem_q[rdPtr_q];
      out_real = realMem_q[rdPtr_q];
      out_imag = imagMem_q[rdPtr_q];
      out_last = lastMem_q[rdPtr_q];
    end else if (inflight_q) begin
      out_bin  = inflightBin_q;
      out_real = dmadr_real;
      out_imag = dmadr_imag;
      out_last = inflightLast_q;
    end
  end

  assign out_valid = validInt;
  assign out_exp   = exp_q;
  assign err_abort = errAbort_q;

endmodule

// File: tb/tb_fft_result_reader.sv
// Testbench for fft_result_reader: model RAM on the DMA side, a queue of
// expected bins per frame, and directed frame/abort/reset scenarios.
module tb_fft_result_reader;

  localparam int FFT_LENGTH = 8;
  localparam int FFT_DW     = 16;
  localparam int OUT_BINS   = 4;
  localparam int FFT_N      = 3;

  typedef struct {
    logic [FFT_N-1:0] bin;
    logic [15:0]      re;
    logic [15:0]      im;
  } binRec_t;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     fft_done;
  logic signed [7:0]        fft_bfpexp;
  logic                     fin;
  logic                     dmaact;
  logic        [FFT_N-1:0]  dmaa;
  logic signed [FFT_DW-1:0] dmadr_real;
  logic signed [FFT_DW-1:0] dmadr_imag;
  logic                     out_valid;
  logic                     out_ready;
  logic        [FFT_N-1:0]  out_bin;
  logic signed [FFT_DW-1:0] out_real;
  logic signed [FFT_DW-1:0] out_imag;
  logic signed [7:0]        out_exp;
  logic                     out_last;
  logic                     busy;
  logic                     err_abort;

  int          nAsserts = 0;
  int          nFails   = 0;
  binRec_t     expQ[$];
  logic [7:0]  expExp;
  int          nextAddr;
  int          issued;
  int          accepted;
  int          finCount;
  logic        lastPopPrev;
  logic [15:0] ramReal [FFT_LENGTH];
  logic [15:0] ramImag [FFT_LENGTH];

  fft_result_reader #(
    .FFT_LENGTH(FFT_LENGTH),
    .FFT_DW    (FFT_DW),
    .OUT_BINS  (OUT_BINS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fft_done  (fft_done),
    .fft_bfpexp(fft_bfpexp),
    .fin       (fin),
    .dmaact    (dmaact),
    .dmaa      (dmaa),
    .dmadr_real(dmadr_real),
    .dmadr_imag(dmadr_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_exp   (out_exp),
    .out_last  (out_last),
    .busy      (busy),
    .err_abort (err_abort)
  );

  always #5 clk = ~clk;

  // Model RAM: data valid the cycle after a read strobe, noise otherwise.
  always @(posedge clk) begin
    if (dmaact) begin
      dmadr_real <= ramReal[dmaa];
      dmadr_imag <= ramImag[dmaa];
    end else begin
      dmadr_real <= 16'($urandom);
      dmadr_imag <= 16'($urandom);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Per-cycle scoreboard: read order, delivered bins, credit bound, fin timing.
  task automatic monitorCycle();
    logic    popNow;
    logic    popLast;
    binRec_t e;
    popNow  = out_valid && out_ready;
    popLast = 1'b0;
    if (dmaact) begin
      checkOutput("dmaa_order", {29'd0, dmaa}, 32'(nextAddr));
      checkOutput("read_in_range", 32'(nextAddr < OUT_BINS), 32'd1);
      nextAddr++;
      issued++;
    end
    if (popNow) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_bin", {31'd0, out_valid}, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("out_bin", {29'd0, out_bin}, {29'd0, e.bin});
        checkOutput("out_real", {16'd0, out_real}, {16'd0, e.re});
        checkOutput("out_imag", {16'd0, out_imag}, {16'd0, e.im});
        checkOutput("out_last", {31'd0, out_last}, 32'(e.bin == FFT_N'(OUT_BINS - 1)));
        checkOutput("out_exp", {24'd0, out_exp}, {24'd0, expExp});
        popLast = (e.bin == FFT_N'(OUT_BINS - 1));
        accepted++;
      end
    end
    checkOutput("outstanding_le2", 32'((issued - accepted) <= 2), 32'd1);
    checkOutput("fin_timing", {31'd0, fin}, {31'd0, lastPopPrev});
    if (fin) finCount++;
    lastPopPrev = popLast;
  endtask

  task automatic applyStimulus(input logic rst, input logic done, input logic ready, input logic [7:0] ex);
    @(posedge clk);
    #1;
    reset      = rst;
    fft_done   = done;
    out_ready  = ready;
    fft_bfpexp = ex;
    @(negedge clk);
    monitorCycle();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_fin"}, {31'd0, fin}, 32'd0);
    checkOutput({tag, "_dmaact"}, {31'd0, dmaact}, 32'd0);
    checkOutput({tag, "_dmaa"}, {29'd0, dmaa}, 32'd0);
    checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_bin"}, {29'd0, out_bin}, 32'd0);
    checkOutput({tag, "_real"}, {16'd0, out_real}, 32'd0);
    checkOutput({tag, "_imag"}, {16'd0, out_imag}, 32'd0);
    checkOutput({tag, "_exp"}, {24'd0, out_exp}, 32'd0);
    checkOutput({tag, "_last"}, {31'd0, out_last}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_err"}, {31'd0, err_abort}, 32'd0);
  endtask

  // New frame: fresh RAM contents and the bins the consumer must deliver.
  task automatic startFrame(input logic [7:0] ex);
    binRec_t r;
    for (int i = 0; i < FFT_LENGTH; i++) begin
      ramReal[i] = 16'($urandom);
      ramImag[i] = 16'($urandom);
    end
    expQ.delete();
    for (int i = 0; i < OUT_BINS; i++) begin
      r.bin = FFT_N'(i);
      r.re  = ramReal[i];
      r.im  = ramImag[i];
      expQ.push_back(r);
    end
    expExp   = ex;
    nextAddr = 0;
    issued   = 0;
    accepted = 0;
    finCount = 0;
  endtask

  // End of frame: one fin, nothing left, no retrigger on a stale done, then idle.
  task automatic closeFrame(input logic [7:0] ex);
    checkOutput("frame_fin_once", 32'(finCount), 32'd1);
    checkOutput("frame_bins_left", 32'(expQ.size()), 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, ex);
      checkOutput("no_retrigger", {31'd0, dmaact}, 32'd0);
      checkOutput("busy_wait_clr", {31'd0, busy}, 32'd1);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, ex);
    checkOutput("idle_after_clr", {31'd0, busy}, 32'd0);
    checkOutput("fin_total", 32'(finCount), 32'd1);
  endtask

  task automatic runFrame(input logic [7:0] exp0, input logic [7:0] expLater, input bit patternMode);
    logic       r;
    logic [6:0] readyPat;
    readyPat = 7'b1001011;
    startFrame(exp0);
    for (int c = 0; c < 200; c++) begin
      if (!patternMode) r = 1'($urandom);
      else if (c < 3 || c > 9) r = 1'b1;
      else r = readyPat[9 - c];
      applyStimulus(1'b0, 1'b1, r, (c >= 2) ? expLater : exp0);
      if (finCount != 0) break;
    end
    closeFrame(expLater);
  endtask

  initial begin
    int t1Act   [9] = '{0, 0, 1, 1, 1, 1, 0, 0, 0};
    int t1Valid [9] = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
    logic [7:0] ex;
    reset = 1'b1; fft_done = 1'b0; out_ready = 1'b0; fft_bfpexp = '0;
    lastPopPrev = 1'b0; expExp = '0; nextAddr = 0; issued = 0; accepted = 0; finCount = 0;

    $display("[TB] reset state");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    checkAllZero("reset");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd0);

    $display("[TB] frame timing, out_ready held high");
    startFrame(8'd5);
    for (int c = 0; c < 9; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 8'd5);
      checkOutput("t1_dmaact", {31'd0, dmaact}, 32'(t1Act[c]));
      if (t1Act[c] != 0) checkOutput("t1_dmaa", {29'd0, dmaa}, 32'(c - 2));
      checkOutput("t1_valid", {31'd0, out_valid}, 32'(t1Valid[c]));
      if (t1Valid[c] != 0) checkOutput("t1_bin", {29'd0, out_bin}, 32'(c - 3));
      checkOutput("t1_last", {31'd0, out_last}, 32'(c == 6));
      checkOutput("t1_fin", {31'd0, fin}, 32'(c == 7));
    end
    closeFrame(8'd5);

    $display("[TB] frame with stalling out_ready");
    ex = 8'($urandom);
    runFrame(ex, ex, 1'b1);

    $display("[TB] exponent changes after latch are ignored");
    runFrame(8'hFD, 8'd5, 1'b0);

    $display("[TB] abort when done falls mid-frame");
    startFrame(8'd7);
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b1, 1'b0, 8'd7);
    checkOutput("abort_two_issued", 32'(issued), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd7);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd7);
    checkOutput("abort_err", {31'd0, err_abort}, 32'd1);
    checkOutput("abort_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'd7);
      checkOutput("abort_no_fin", {31'd0, fin}, 32'd0);
      checkOutput("abort_no_read", {31'd0, dmaact}, 32'd0);
    end
    checkOutput("abort_sticky", {31'd0, err_abort}, 32'd1);

    $display("[TB] reset mid-frame with a buffered bin");
    startFrame(8'd9);
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b1, 1'b0, 8'd9);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd9);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd9);
    checkAllZero("midreset");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd9);
    ex = 8'($urandom);
    runFrame(ex, ex, 1'b0);

    $display("[TB] back-to-back frames");
    for (int f = 0; f < 3; f++) begin
      ex = 8'($urandom);
      runFrame(ex, 8'($urandom), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
